// File: rtl/s38584_pkg.sv
// Shared definitions for the s38584 lane-select encoder.
//   phase_t     : FSM state encoding, driven directly onto PHASE
//   LANE0..3    : 2-bit lane codes {hi,lo} carried on SEL
//   TMO_DEFAULT : default ACK-wait limit in cycles
//   lane_onehot : lane code -> one-hot grant vector
package s38584_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'b000,
        PH_ARB  = 3'b001,
        PH_SEND = 3'b011,
        PH_HOLD = 3'b111,
        PH_DONE = 3'b110
    } phase_t;

    localparam logic [1:0] LANE0 = 2'b00;
    localparam logic [1:0] LANE1 = 2'b01;
    localparam logic [1:0] LANE2 = 2'b10;
    localparam logic [1:0] LANE3 = 2'b11;

    localparam logic [3:0] TMO_DEFAULT = 4'd12;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/s38584_sel_encoder_if.sv
// Request/grant bundle between a requester/receiver and the lane-select encoder.
//   EN    : enable; low freezes the encoder
//   REQ   : per-lane transfer requests (level)
//   ACK   : receiver acknowledge of the current lane code
//   SEL   : granted lane code
//   PHASE : encoded FSM state
//   VLD   : SEL/GNT valid for the receiver
//   GNT   : one-hot granted lane
//   ABORT : one-cycle pulse on ACK timeout
// master = requester/receiver side, slave = encoder side.
interface s38584_sel_encoder_if;
    logic       EN;
    logic [3:0] REQ;
    logic       ACK;
    logic [1:0] SEL;
    logic [2:0] PHASE;
    logic       VLD;
    logic [3:0] GNT;
    logic       ABORT;

    modport master (
        output EN, REQ, ACK,
        input  SEL, PHASE, VLD, GNT, ABORT
    );

    modport slave (
        input  EN, REQ, ACK,
        output SEL, PHASE, VLD, GNT, ABORT
    );
endinterface

// File: rtl/s38584_rr_arb4.sv
// Combinational 4-lane rotating-priority search.
//   req        : request vector
//   last_grant : lane granted most recently; search starts at last_grant+1
//   winner     : first requesting lane in rotated order (don't-care if req==0)
module s38584_rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] winner
);
    logic [1:0] start;
    logic [7:0] req_dbl;
    logic [3:0] rot;
    logic [1:0] offset;

    // Doubling the vector lets a plain part-select perform the rotation:
    // rot[k] is the request of lane (start+k) mod 4.
    assign start   = last_grant + 2'd1;
    assign req_dbl = {req, req};
    assign rot     = req_dbl[start +: 4];

    always_comb begin
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) offset = 2'(k);
        end
    end

    // Wraps naturally in 2 bits.
    assign winner = start + offset;
endmodule

// File: rtl/s38584_sel_encoder.sv
// Round-robin lane-select encoder with ACK handshake and timeout.
//   CK  : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : slave side of s38584_sel_encoder_if (EN/REQ/ACK in,
//         SEL/PHASE/VLD/GNT/ABORT out, all outputs registered)
// Flow: IDLE -> ARB (pick lane) -> SEND -> HOLD (wait ACK) -> DONE -> IDLE.
// A HOLD that sees no ACK for TMO cycles pulses ABORT and returns to IDLE
// without advancing the round-robin pointer, so the same lane wins again.
module s38584_sel_encoder
    import s38584_pkg::*;
#(
    parameter logic [3:0] TMO = TMO_DEFAULT
) (
    input  logic                  CK,
    input  logic                  RST,
    s38584_sel_encoder_if.slave   bus
);
    phase_t     state;
    logic [1:0] sel_r;
    logic [3:0] gnt_r;
    logic       vld_r;
    logic       abort_r;
    logic [3:0] wait_cnt;
    logic [1:0] last_grant;
    logic [1:0] winner;

    s38584_rr_arb4 u_arb (
        .req        (bus.REQ),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state      <= PH_IDLE;
            sel_r      <= LANE0;
            gnt_r      <= 4'b0000;
            vld_r      <= 1'b0;
            abort_r    <= 1'b0;
            wait_cnt   <= 4'd0;
            last_grant <= LANE3;
        end else if (!bus.EN) begin
            // Everything holds; only the ABORT pulse is forced low.
            abort_r <= 1'b0;
        end else begin
            abort_r <= 1'b0;
            case (state)
                PH_IDLE: begin
                    if (|bus.REQ) state <= PH_ARB;
                end
                PH_ARB: begin
                    if (|bus.REQ) begin
                        sel_r <= winner;
                        gnt_r <= lane_onehot(winner);
                        vld_r <= 1'b1;
                        state <= PH_SEND;
                    end else begin
                        state <= PH_IDLE;
                    end
                end
                PH_SEND: begin
                    wait_cnt <= 4'd0;
                    state    <= PH_HOLD;
                end
                PH_HOLD: begin
                    // ACK is checked first so it wins over a coincident timeout.
                    if (bus.ACK) begin
                        last_grant <= sel_r;
                        vld_r      <= 1'b0;
                        state      <= PH_DONE;
                    end else if (wait_cnt == TMO - 4'd1) begin
                        abort_r <= 1'b1;
                        vld_r   <= 1'b0;
                        state   <= PH_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                PH_DONE: begin
                    state <= PH_IDLE;
                end
                default: begin
                    state <= PH_IDLE;
                    vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PHASE = state;
    assign bus.SEL   = sel_r;
    assign bus.GNT   = gnt_r;
    assign bus.VLD   = vld_r;
    assign bus.ABORT = abort_r;
endmodule

// File: tb/tb_s38584_sel_encoder.sv
// Testbench for s38584_sel_encoder: directed scenarios plus randomized
// transfers checked against a transaction-level model (round-robin pick
// from the last completed grant, ACK-or-timeout outcome from the wait length).
module tb_s38584_sel_encoder;
    localparam int TMO_CYC = 12;

    logic CK = 1'b0;
    logic RST;

    s38584_sel_encoder_if bus ();

    s38584_sel_encoder #(.TMO(4'd12)) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CK = ~CK;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] mdl_last;

    // Lane that should win: first requesting lane after the last completed grant.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        int lane;
        rr_pick = last;
        for (int i = 1; i <= 4; i++) begin
            lane = (int'(last) + i) % 4;
            if (req[lane]) return 2'(lane);
        end
    endfunction

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // One transfer from IDLE. ack_at: HOLD cycle (0-based, counting enabled
    // cycles only) in which ACK is high; -1 for never. gap_at/gap_len: EN held
    // low for gap_len cycles before HOLD cycle gap_at.
    task automatic do_transfer(input logic [3:0] req, input int ack_at,
                               input int gap_at, input int gap_len, input string tag);
        logic [1:0]  lane;
        logic [3:0]  oh;
        logic [10:0] obs, want;
        lane = rr_pick(req, mdl_last);
        oh   = 4'b0001 << lane;
        bus.EN = 1'b1; bus.ACK = 1'b0; bus.REQ = req;
        step();
        vectors++;
        if (bus.PHASE !== 3'b001 || bus.VLD !== 1'b0) begin
            miscompares++;
            $display("FAIL %s arb: phase=%b vld=%b, want phase=001 vld=0", tag, bus.PHASE, bus.VLD);
        end
        step();
        obs  = {bus.PHASE, bus.VLD, bus.SEL, bus.GNT, bus.ABORT};
        want = {3'b011, 1'b1, lane, oh, 1'b0};
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL %s send: {ph,vld,sel,gnt,abort}=%b, want %b", tag, obs, want);
        end
        step();
        obs  = {bus.PHASE, bus.VLD, bus.SEL, bus.GNT, bus.ABORT};
        want = {3'b111, 1'b1, lane, oh, 1'b0};
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL %s hold_entry: {ph,vld,sel,gnt,abort}=%b, want %b", tag, obs, want);
        end
        for (int h = 0; h < 64; h++) begin
            if (h == gap_at) begin
                bus.EN = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    bus.ACK = 1'($urandom_range(0, 1));
                    step();
                    obs  = {bus.PHASE, bus.VLD, bus.SEL, bus.GNT, bus.ABORT};
                    want = {3'b111, 1'b1, lane, oh, 1'b0};
                    vectors++;
                    if (obs !== want) begin
                        miscompares++;
                        $display("FAIL %s frozen(h=%0d,g=%0d): {ph,vld,sel,gnt,abort}=%b, want %b",
                                 tag, h, g, obs, want);
                    end
                end
                bus.EN = 1'b1;
            end
            bus.ACK = (h == ack_at);
            step();
            obs = {bus.PHASE, bus.VLD, bus.SEL, bus.GNT, bus.ABORT};
            if (h == ack_at) begin
                vectors++;
                if (bus.PHASE !== 3'b110 || bus.VLD !== 1'b0 || bus.ABORT !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s done(h=%0d): ph=%b vld=%b abort=%b, want ph=110 vld=0 abort=0",
                             tag, h, bus.PHASE, bus.VLD, bus.ABORT);
                end
                mdl_last = lane;
                break;
            end else if (h == TMO_CYC - 1) begin
                vectors++;
                if (bus.PHASE !== 3'b000 || bus.VLD !== 1'b0 || bus.ABORT !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s timeout(h=%0d): ph=%b vld=%b abort=%b, want ph=000 vld=0 abort=1",
                             tag, h, bus.PHASE, bus.VLD, bus.ABORT);
                end
                break;
            end else begin
                want = {3'b111, 1'b1, lane, oh, 1'b0};
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL %s hold(h=%0d): {ph,vld,sel,gnt,abort}=%b, want %b", tag, h, obs, want);
                end
            end
        end
        bus.ACK = 1'b0; bus.REQ = 4'b0000;
        step();
        vectors++;
        if (bus.PHASE !== 3'b000 || bus.VLD !== 1'b0 || bus.ABORT !== 1'b0) begin
            miscompares++;
            $display("FAIL %s back_idle: ph=%b vld=%b abort=%b, want ph=000 vld=0 abort=0",
                     tag, bus.PHASE, bus.VLD, bus.ABORT);
        end
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        bus.EN = 1'b0; bus.REQ = 4'b0000; bus.ACK = 1'b0;
        RST = 1'b1;
        step(); step();
        obs = {bus.PHASE, bus.VLD, bus.SEL, bus.GNT, bus.ABORT};
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: {ph,vld,sel,gnt,abort}=%b, want 0", obs);
        end
        RST = 1'b0;
        mdl_last = 2'd3;
        step();
        obs = {bus.PHASE, bus.VLD, bus.SEL, bus.GNT, bus.ABORT};
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_release: {ph,vld,sel,gnt,abort}=%b, want 0", obs);
        end
    endtask

    task automatic test_single_lane2();
        test_reset();
        do_transfer(4'b0100, 1, -1, 0, "lane2_ack2");
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [5];
        seq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b000};
        test_reset();
        bus.EN = 1'b1; bus.REQ = 4'b1111; bus.ACK = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int s = 0; s < 5; s++) begin
                step();
                vectors++;
                if (bus.PHASE !== seq[s]) begin
                    miscompares++;
                    $display("FAIL b2b phase(t=%0d,s=%0d): got %b, want %b", t, s, bus.PHASE, seq[s]);
                end
                if (s == 1) begin
                    vectors++;
                    if (bus.SEL !== 2'(t) || bus.GNT !== (4'b0001 << t) || bus.VLD !== 1'b1) begin
                        miscompares++;
                        $display("FAIL b2b grant(t=%0d): sel=%b gnt=%b vld=%b, want sel=%0d gnt=%b vld=1",
                                 t, bus.SEL, bus.GNT, bus.VLD, t, 4'b0001 << t);
                    end
                end
            end
        end
        bus.ACK = 1'b0; bus.REQ = 4'b0000;
        mdl_last = 2'd3;
        step();
    endtask

    task automatic test_timeout_regrant();
        do_transfer(4'b1010, -1, -1, 0, "timeout");
        do_transfer(4'b1010, 0, -1, 0, "regrant_after_timeout");
    endtask

    task automatic test_ack_at_timeout();
        do_transfer(4'b0010, TMO_CYC - 1, -1, 0, "ack_on_timeout");
    endtask

    task automatic test_en_freeze();
        do_transfer(4'b0100, -1, 3, 5, "en_freeze_hold");
    endtask

    task automatic test_enable_idle();
        bus.EN = 1'b0; bus.REQ = 4'b0011; bus.ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.PHASE !== 3'b000 || bus.VLD !== 1'b0) begin
                miscompares++;
                $display("FAIL en_low_idle(%0d): ph=%b vld=%b, want ph=000 vld=0", i, bus.PHASE, bus.VLD);
            end
        end
        do_transfer(4'b0011, 2, -1, 0, "after_en_low");
    endtask

    task automatic test_withdraw();
        bus.EN = 1'b1; bus.REQ = 4'b1000; bus.ACK = 1'b0;
        step();
        bus.REQ = 4'b0000;
        step();
        vectors++;
        if (bus.PHASE !== 3'b000 || bus.VLD !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw: ph=%b vld=%b, want ph=000 vld=0", bus.PHASE, bus.VLD);
        end
        do_transfer(4'b1001, 0, -1, 0, "after_withdraw");
    endtask

    task automatic test_async_reset();
        logic [10:0] obs;
        bus.EN = 1'b1; bus.REQ = 4'b0110; bus.ACK = 1'b0;
        step(); step();
        vectors++;
        if (bus.PHASE !== 3'b011) begin
            miscompares++;
            $display("FAIL async_rst_pre: ph=%b, want 011", bus.PHASE);
        end
        #3 RST = 1'b1;
        #1;
        obs = {bus.PHASE, bus.VLD, bus.SEL, bus.GNT, bus.ABORT};
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("FAIL async_rst: {ph,vld,sel,gnt,abort}=%b, want 0", obs);
        end
        #1 RST = 1'b0;
        mdl_last = 2'd3;
        do_transfer(4'b0001, 0, -1, 0, "after_async_rst");
    endtask

    task automatic test_random();
        logic [3:0] req;
        int ack_at, gap_at, gap_len;
        for (int n = 0; n < 30; n++) begin
            req     = 4'($urandom_range(1, 15));
            ack_at  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 13));
            gap_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
            gap_len = int'($urandom_range(1, 6));
            do_transfer(req, ack_at, gap_at, gap_len, "random");
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.EN = 1'b0; bus.REQ = 4'b0000; bus.ACK = 1'b0;
        mdl_last = 2'd3;
        test_reset();
        test_single_lane2();
        test_back_to_back();
        test_timeout_regrant();
        test_ack_at_timeout();
        test_en_freeze();
        test_enable_idle();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/s38584_sel_encoder.md
S38584_SEL_ENCODER -- requirements
Module: s38584_sel_encoder

Interface
REQ-001 SHALL have parameter TMO, default 4'd12, meaning the ACK-wait limit in cycles (range 1..15).
REQ-002 SHALL have port CK  input  1  meaning the single clock; all state is captured on the rising edge.
REQ-003 SHALL have port RST  input  1  meaning the reset; asynchronous, active-high.
REQ-004 SHALL have port EN  input  1  meaning the enable; when low, the FSM holds its state and counters freeze.
REQ-005 SHALL have port REQ  input  4  meaning the per-lane transfer requests, level-sensitive.
REQ-006 SHALL have port ACK  input  1  meaning the receiver acknowledges the current lane code.
REQ-007 SHALL have port SEL  output  2  meaning the granted lane code {hi,lo}: 00=lane0, 01=lane1, 10=lane2, 11=lane3.
REQ-008 SHALL have port PHASE  output  3  meaning the encoded FSM state.
REQ-009 SHALL have port VLD  output  1  meaning SEL is valid for the receiver.
REQ-010 SHALL have port GNT  output  4  meaning a one-hot copy of the granted lane, valid with VLD.
REQ-011 SHALL have port ABORT  output  1  meaning a one-cycle pulse on ACK timeout.

Function
REQ-012 SHALL implement FSM states IDLE=000, ARB=001, SEND=011, HOLD=111, DONE=110, driven directly on PHASE.
REQ-013 SHALL transition IDLE->ARB when EN=1 and REQ!=0; otherwise IDLE holds.
REQ-014 SHALL perform round-robin arbitration in ARB: search starts at lane (last_grant+1) mod 4; the winner is latched into a 2-bit grant register; then ARB->SEND.
REQ-015 SHALL return ARB->IDLE with no grant update if REQ==0 in ARB (request withdrawn).
REQ-016 SHALL assert VLD=1 in SEND and HOLD only, with SEL and GNT stable from SEND entry until leaving HOLD.
REQ-017 SHALL go SEND->HOLD unconditionally after 1 cycle and clear the wait counter.
REQ-018 SHALL go HOLD->DONE when ACK=1, and update last_grant to the granted lane.
REQ-019 SHALL increment the 4-bit wait counter in HOLD when ACK=0; at count==TMO-1 it SHALL pulse ABORT for 1 cycle and go HOLD->IDLE without updating last_grant.
REQ-020 SHALL give ACK priority when ACK=1 and the timeout occur in the same cycle: DONE, no ABORT.
REQ-021 SHALL go DONE->IDLE after 1 cycle with VLD=0; minimum request-to-VLD latency is 2 cycles (IDLE->ARB->SEND).
REQ-022 SHALL ignore ACK outside HOLD.
REQ-023 SHALL freeze the state, counter, ABORT (held 0) and outputs when EN=0; operation resumes exactly where it stopped.
REQ-024 SHALL register all outputs; no combinational path from input to output.

Reset
REQ-025 SHALL on RST=1 immediately force state IDLE, PHASE=000, SEL=00, GNT=0000, VLD=0, ABORT=0, wait counter=0, and last_grant=3, so that lane 0 has first priority.
REQ-026 SHALL abandon any transfer in progress when RST asserts mid-transfer, with no ABORT pulse.

Structure
REQ-027 SHALL keep the phase encodings, lane codes and TMO default in shared package s38584_pkg.
REQ-028 SHALL place the rotate-priority search in a single sub-module s38584_rr_arb4 (REQ, last_grant -> winner index), which is purely combinational.

Verification
REQ-029 SHALL cover this case: reset, then REQ=0100, then ACK 2 cycles after VLD -> SEL=10, GNT=0100, PHASE sequence 001,011,111,111,110,000, and ABORT never asserts.
REQ-030 SHALL cover this case: REQ=1111 held across four serviced transfers with immediate ACK -> grants in the order lane0,1,2,3.
REQ-031 SHALL cover this case: ACK never asserted, TMO=12 -> ABORT pulses once 12 cycles after HOLD entry, then IDLE, and the same lane is regranted next.
REQ-032 SHALL cover this case: ACK=1 on the same cycle as the timeout -> DONE, ABORT=0.
REQ-033 SHALL cover this case: EN dropped for 5 cycles in HOLD -> the counter and outputs are frozen, and the timeout is delayed by exactly 5 cycles.
REQ-034 SHALL cover this case: RST asserted mid-SEND, asynchronously -> all outputs are 0 before the next edge, and after release REQ=0001 is granted lane 0.
